// File: rtl/selftest_initiator.sv
// Purpose : host-side initiator that launches NUM_RUNS self-test runs and tallies pass/fail/timeout verdicts.
// Latency : outputs are registered; dev_start/busy/done follow the FSM state by one cycle.
// Backpressure: none; go is honoured only in IDLE and is dropped (not queued) while busy.
//
// Ports:
//   clk, rstn            clock (rising edge) and asynchronous active-low reset
//   go                   start request, sampled only in IDLE
//   dev_start            one-cycle launch pulse to the device
//   dev_data[7:0]        per-run pattern (SEED rotated left once per run)
//   dev_pass, dev_fail   device verdict inputs, honoured only in RUN (fail wins)
//   busy                 high while a sequence is in progress
//   done                 one-cycle pulse at the end of a sequence
//   all_pass             every run passed; held until the next accepted go
//   pass_cnt, fail_cnt, tmo_cnt  per-sequence verdict counters
module selftest_initiator #(
    parameter int          NUM_RUNS = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        go,
    output logic        dev_start,
    output logic [7:0]  dev_data,
    input  logic        dev_pass,
    input  logic        dev_fail,
    output logic        busy,
    output logic        done,
    output logic        all_pass,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic [7:0]  tmo_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [7:0] LAST_RUN = 8'(NUM_RUNS - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] RUNS_8   = 8'(NUM_RUNS);

    logic [2:0] state;
    logic [7:0] run_idx;
    logic [7:0] timer;
    logic       verdict;

    // Any of these ends the current run; which counter moves is decided below.
    always_comb begin
        verdict = dev_fail | dev_pass | (timer == TMO_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            run_idx   <= 8'd0;
            timer     <= 8'd0;
            dev_start <= 1'b0;
            dev_data  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            all_pass  <= 1'b0;
            pass_cnt  <= 8'd0;
            fail_cnt  <= 8'd0;
            tmo_cnt   <= 8'd0;
        end else begin
            // Status outputs are registered decodes of the current state, so
            // they appear one cycle after the state they describe.
            dev_start <= (state == S_LAUNCH);
            busy      <= (state != S_IDLE);
            done      <= (state == S_DONE);

            case (state)
                S_IDLE: begin
                    if (go) begin
                        state    <= S_LAUNCH;
                        pass_cnt <= 8'd0;
                        fail_cnt <= 8'd0;
                        tmo_cnt  <= 8'd0;
                        all_pass <= 1'b0;
                        run_idx  <= 8'd0;
                        dev_data <= SEED;
                    end
                end

                S_LAUNCH: begin
                    timer <= 8'd0;
                    state <= S_RUN;
                end

                S_RUN: begin
                    if (dev_fail) begin
                        fail_cnt <= fail_cnt + 8'd1;
                    end else if (dev_pass) begin
                        pass_cnt <= pass_cnt + 8'd1;
                    end else if (timer == TMO_LAST) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end else begin
                        timer <= timer + 8'd1;
                    end

                    if (verdict) begin
                        state <= (run_idx == LAST_RUN) ? S_DONE : S_GAP;
                    end
                end

                S_GAP: begin
                    run_idx  <= run_idx + 8'd1;
                    dev_data <= {dev_data[6:0], dev_data[7]};
                    state    <= S_LAUNCH;
                end

                S_DONE: begin
                    all_pass <= (pass_cnt == RUNS_8);
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/selftest_initiator.md
# selftest_initiator

Host-side initiator for the pass/fail self-test device: launches a fixed number of test runs, drives a per-run data pattern, and collects each run's verdict (pass, fail, or timeout). Sits between the system control register block and the device's start/data/pass/fail pins. Reports a one-cycle done pulse and a summary after the last run.

## Interface
- NUM_RUNS, default 4: runs per go request; legal range 1..255.
- TIMEOUT, default 255: maximum RUN-state cycles per run before a timeout is declared; legal range 2..255.
- SEED, default 8'hA5: data pattern for run 0.

- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- go  input  1  start request; sampled only in IDLE.
- dev_start  output  1  one-cycle launch pulse to the device.
- dev_data  output  8  pattern to the device; stable from LAUNCH through RUN.
- dev_pass  input  1  device pass indication.
- dev_fail  input  1  device fail indication.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the sequence ends.
- all_pass  output  1  set at done if pass_cnt == NUM_RUNS; held until the next accepted go.
- pass_cnt, fail_cnt, tmo_cnt  output  8 each  per-sequence result counters.

## Operation
- Reset values: state IDLE; dev_start 0, dev_data 8'h00, busy 0, done 0, all_pass 0, all counters 0, run index 0, timer 0. Reset mid-sequence aborts immediately; no done pulse is emitted.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, RUN, GAP, DONE.
- IDLE: go=1 -> LAUNCH. Clear pass_cnt, fail_cnt, tmo_cnt and all_pass; set run index 0 and dev_data = SEED.
- LAUNCH: dev_start=1 for exactly this cycle; clear timer; -> RUN. dev_pass/dev_fail are ignored in this state.
- RUN: evaluate in this priority order:
  - dev_fail=1: fail_cnt+1. Fail wins if dev_pass=1 in the same cycle.
  - else dev_pass=1: pass_cnt+1.
  - else timer == TIMEOUT-1: tmo_cnt+1.
  - else timer+1; stay in RUN.
  - When a verdict is recorded: if run index == NUM_RUNS-1, go to DONE; otherwise go to GAP.
- GAP: one cycle. Run index+1; dev_data rotates left by 1 (8'hA5 -> 8'h4B); -> LAUNCH.
- DONE: done=1 for this cycle; all_pass = (pass_cnt == NUM_RUNS); -> IDLE.
- Counters, all_pass and the last dev_data hold in IDLE until the next accepted go.
- go while busy is ignored; it is not queued.
- Counters cannot overflow because NUM_RUNS ≤ 255.

## Timing
- go sampled high in IDLE at edge N: busy=1 and dev_start=1 after edge N+1. The first RUN cycle follows.
- Fastest run: verdict in the first RUN cycle. Each run then takes 3 cycles (LAUNCH, RUN, GAP); the final run takes LAUNCH, RUN, DONE.
- Timeout: a silent device is held in RUN for exactly TIMEOUT cycles.
- A verdict arriving in the same cycle as timer == TIMEOUT-1 counts as that verdict, not as a timeout.
- done and busy deassert together: busy=0 in the cycle after done.
- A go in the cycle after done, with state IDLE, is accepted.

## Test plan
- NUM_RUNS=4; device pulses dev_pass 2 cycles after each dev_start -> pass_cnt=4, fail_cnt=0, tmo_cnt=0, all_pass=1, one done pulse; dev_data sequence A5, 4B, 96, 2D.
- Device never responds, TIMEOUT=10 -> each RUN lasts exactly 10 cycles; tmo_cnt=4, all_pass=0; done pulses 4×(1+10+1)=48 cycles after the first LAUNCH.
- dev_pass and dev_fail high together on run 1, pass on other runs -> fail_cnt=1, pass_cnt=3, all_pass=0.
- dev_pass asserted in the LAUNCH cycle only, then silence, TIMEOUT=5 -> the LAUNCH-cycle pass is ignored; tmo_cnt=1 for that run.
- go re-asserted every cycle during a sequence -> still exactly one done pulse, counters reflect 4 runs; go after done restarts with counters cleared.
- rstn low during RUN of run 2 -> all outputs return to reset values asynchronously, no done pulse; a subsequent go starts a fresh sequence from SEED.
